// File: rtl/cofre_senha_seq_if.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_senha_seq_if
//  Description : Strobe/status bundle between the board-level top (master)
//                and the multi-digit code controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cofre_senha_seq_if #(
  parameter int DIGITS    = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_TRIES = 3
);
  localparam int CNT_W = $clog2(DIGITS + 1);
  localparam int TRY_W = $clog2(MAX_TRIES + 1);

  logic               enter_i;
  logic [DIGIT_W-1:0] digit_i;
  logic               close_i;
  logic               prog_i;
  logic               h_i;

  logic               open_o;
  logic               locked_out_o;
  logic               err_o;
  logic [CNT_W-1:0]   digits_in_o;
  logic [TRY_W-1:0]   tries_left_o;
  logic [2:0]         estado_o;

  modport master (
    output enter_i, digit_i, close_i, prog_i, h_i,
    input  open_o, locked_out_o, err_o, digits_in_o, tries_left_o, estado_o
  );

  modport slave (
    input  enter_i, digit_i, close_i, prog_i, h_i,
    output open_o, locked_out_o, err_o, digits_in_o, tries_left_o, estado_o
  );
endinterface
`default_nettype wire

// File: rtl/cofre_senha_seq.sv
`default_nettype none
// ============================================================================
//  Module      : cofre_senha_seq
//  Description : Multi-digit safe code controller: digit entry with idle
//                timeout, code check, open/relock, code reprogramming while
//                open, and timed lockout after repeated failures.
//                Optional macro COFRE_EMERG_EN enables the emergency key H.
//  Revision    : 1.0 - initial release
// ============================================================================
module cofre_senha_seq #(
  parameter int                          DIGITS        = 4,
  parameter int                          DIGIT_W       = 4,
  parameter logic [DIGITS*DIGIT_W-1:0]   DEFAULT_PW    = 16'h1234,
  parameter int                          MAX_TRIES     = 3,
  parameter int                          LOCK_CYCLES   = 20,
  parameter int                          ENTRY_TIMEOUT = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  cofre_senha_seq_if.slave bus
);

  localparam int PW_W    = DIGITS * DIGIT_W;
  localparam int CNT_W   = $clog2(DIGITS + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int TMR_MAX = (LOCK_CYCLES > ENTRY_TIMEOUT) ? LOCK_CYCLES : ENTRY_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ENTRY  = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_OPEN   = 3'd3;
  localparam logic [2:0] S_PROG   = 3'd4;
  localparam logic [2:0] S_LOCKED = 3'd5;

  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);
  localparam logic [TRY_W-1:0] TRIES_FULL = TRY_W'(MAX_TRIES);
  localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(ENTRY_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] LOCK_LAST  = TMR_W'(LOCK_CYCLES - 1);

  logic [2:0]       state_q, state_d;
  logic [PW_W-1:0]  buf_q,   buf_d;
  logic [PW_W-1:0]  code_q,  code_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic [TMR_W-1:0] tmr_q,   tmr_d;
  logic             open_q,  open_d;
  logic             lock_q,  lock_d;
  logic             err_q,   err_d;

  logic [PW_W-1:0]  w_shift;
  logic             w_mismatch;
  logic             w_emerg;

  // Capture buffer with the incoming digit shifted in at the LS position
  generate
    if (DIGITS == 1) begin : g_shift_single
      assign w_shift = bus.digit_i;
    end else begin : g_shift_multi
      assign w_shift = {buf_q[PW_W-DIGIT_W-1:0], bus.digit_i};
    end
  endgenerate

  assign w_mismatch = (buf_q != code_q);

`ifdef COFRE_EMERG_EN
  assign w_emerg = bus.h_i;
`else
  // Key input kept only for pin compatibility
  logic w_unused_h;
  assign w_unused_h = bus.h_i;
  assign w_emerg    = 1'b0;
`endif

  // State and datapath registers, asynchronously cleared to the power-on code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      code_q  <= DEFAULT_PW;
      cnt_q   <= '0;
      tries_q <= TRIES_FULL;
      tmr_q   <= '0;
      open_q  <= 1'b0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      tries_q <= tries_d;
      tmr_q   <= tmr_d;
      open_q  <= open_d;
      lock_q  <= lock_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; emergency key overrides everything last
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    tries_d = tries_q;
    tmr_d   = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.enter_i) begin
          buf_d   = w_shift;
          cnt_d   = cnt_q + CNT_W'(1);
          tmr_d   = '0;
          state_d = (DIGITS == 1) ? S_CHECK : S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (bus.enter_i) begin
          buf_d = w_shift;
          cnt_d = cnt_q + CNT_W'(1);
          tmr_d = '0;
          if (cnt_q == LAST_DIGIT) state_d = S_CHECK;
        end else if (tmr_q == TO_LAST) begin
          // Abandoned entry: discard silently, no failure counted
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      S_CHECK: begin
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
        if (!w_mismatch) begin
          state_d = S_OPEN;
          tries_d = TRIES_FULL;
        end else begin
          tries_d = tries_q - TRY_W'(1);
          state_d = (tries_q == TRY_W'(1)) ? S_LOCKED : S_IDLE;
        end
      end
      S_OPEN: begin
        if (bus.close_i) begin
          state_d = S_IDLE;
        end else if (bus.prog_i && bus.enter_i) begin
          if (DIGITS == 1) begin
            code_d = w_shift;
          end else begin
            buf_d   = w_shift;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = S_PROG;
          end
        end
      end
      S_PROG: begin
        // Aborts win over a same-cycle digit; the old code is kept
        if (bus.close_i || !bus.prog_i) begin
          state_d = bus.close_i ? S_IDLE : S_OPEN;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (bus.enter_i) begin
          if (cnt_q == LAST_DIGIT) begin
            code_d  = w_shift;
            buf_d   = '0;
            cnt_d   = '0;
            state_d = S_OPEN;
          end else begin
            buf_d = w_shift;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_LOCKED: begin
        if (tmr_q == LOCK_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
          tries_d = TRIES_FULL;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        buf_d   = '0;
        cnt_d   = '0;
        tmr_d   = '0;
      end
    endcase
    if (w_emerg) begin
      state_d = S_OPEN;
      buf_d   = '0;
      code_d  = code_q;
      cnt_d   = '0;
      tmr_d   = '0;
      tries_d = TRIES_FULL;
    end
  end

  // Registered status flags decoded from the upcoming state
  always_comb begin
    open_d = (state_d == S_OPEN) || (state_d == S_PROG);
    lock_d = (state_d == S_LOCKED);
    err_d  = (state_q == S_CHECK) && w_mismatch && !w_emerg;
  end

  assign bus.open_o       = open_q;
  assign bus.locked_out_o = lock_q;
  assign bus.err_o        = err_q;
  assign bus.digits_in_o  = cnt_q;
  assign bus.tries_left_o = tries_q;
  assign bus.estado_o     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_cofre_senha_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cofre_senha_seq
//  Description : Self-checking bench for cofre_senha_seq: per-cycle vector
//                table plus hand-written lockout, reset and emergency runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cofre_senha_seq;

  localparam int DIGITS        = 4;
  localparam int DIGIT_W       = 4;
  localparam int MAX_TRIES     = 3;
  localparam int LOCK_CYCLES   = 20;
  localparam int ENTRY_TIMEOUT = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cofre_senha_seq_if #(.DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES)) ifc ();

  cofre_senha_seq #(
    .DIGITS(DIGITS), .DIGIT_W(DIGIT_W), .DEFAULT_PW(16'h1234),
    .MAX_TRIES(MAX_TRIES), .LOCK_CYCLES(LOCK_CYCLES), .ENTRY_TIMEOUT(ENTRY_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(ifc)
  );

  // exp = {open, locked_out, err, digits_in[2:0], tries_left[1:0], estado[2:0]}
  typedef struct packed {
    logic        en;
    logic [3:0]  dg;
    logic        cl;
    logic        pr;
    logic        h;
    logic [10:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] sb_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [10:0] E(bit op, bit lk, bit er, int din, int tr, int es);
    return {op, lk, er, 3'(din), 2'(tr), 3'(es)};
  endfunction

  function automatic vec_t V(bit en, int dg, bit cl, bit pr, bit h, logic [10:0] e);
    vec_t v;
    v.en = en; v.dg = 4'(dg); v.cl = cl; v.pr = pr; v.h = h; v.exp = e;
    return v;
  endfunction

  task automatic compare(input string name);
    logic [10:0] act, e;
    act = {ifc.open_o, ifc.locked_out_o, ifc.err_o, ifc.digits_in_o, ifc.tries_left_o, ifc.estado_o};
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got open=%0b lk=%0b err=%0b din=%0d tries=%0d est=%0d, want open=%0b lk=%0b err=%0b din=%0d tries=%0d est=%0d",
                 name, act[10], act[9], act[8], act[7:5], act[4:3], act[2:0],
                 e[10], e[9], e[8], e[7:5], e[4:3], e[2:0]);
      end
    end
  endtask

  task automatic drive_idle();
    ifc.enter_i = 1'b0; ifc.digit_i = '0; ifc.close_i = 1'b0; ifc.prog_i = 1'b0; ifc.h_i = 1'b0;
  endtask

  // Apply one cycle of inputs, then check outputs on the falling edge
  task automatic step(input vec_t v, input string name);
    ifc.enter_i = v.en; ifc.digit_i = v.dg; ifc.close_i = v.cl;
    ifc.prog_i  = v.pr; ifc.h_i     = v.h;
    sb_q.push_back(v.exp);
    @(posedge clk);
    @(negedge clk);
    compare(name);
  endtask

  task automatic add_code(input int a, input int b, input int c, input int d, input int tr);
    tbl.push_back(V(1, a, 0, 0, 0, E(0, 0, 0, 1, tr, 1)));
    tbl.push_back(V(1, b, 0, 0, 0, E(0, 0, 0, 2, tr, 1)));
    tbl.push_back(V(1, c, 0, 0, 0, E(0, 0, 0, 3, tr, 1)));
    tbl.push_back(V(1, d, 0, 0, 0, E(0, 0, 0, 4, tr, 2)));
  endtask

  task automatic run_code(input int a, input int b, input int c, input int d, input int tr, input string name);
    step(V(1, a, 0, 0, 0, E(0, 0, 0, 1, tr, 1)), name);
    step(V(1, b, 0, 0, 0, E(0, 0, 0, 2, tr, 1)), name);
    step(V(1, c, 0, 0, 0, E(0, 0, 0, 3, tr, 1)), name);
    step(V(1, d, 0, 0, 0, E(0, 0, 0, 4, tr, 2)), name);
  endtask

  // Three wrong codes in a row, ending on the edge that enters LOCKED
  task automatic fail_three();
    for (int k = 1; k <= 3; k++) begin
      run_code(1, 2, 3, 5, 4 - k, "bad_entry");
      step(V(0, 0, 0, 0, 0, E(0, (k == 3), 1, 0, 3 - k, (k == 3) ? 5 : 0)), "bad_check");
    end
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.push_back(E(0, 0, 0, 0, 3, 0));
    compare("reset_state");
    rst_n = 1'b1;

    // Correct default code; enter during CHECK is ignored; close relocks
    add_code(1, 2, 3, 4, 3);
    tbl.push_back(V(1, 7, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(0, 0, 1, 0, 0, E(0, 0, 0, 0, 3, 0)));
    // Entry timeout after two digits
    tbl.push_back(V(1, 1, 0, 0, 0, E(0, 0, 0, 1, 3, 1)));
    tbl.push_back(V(1, 2, 0, 0, 0, E(0, 0, 0, 2, 3, 1)));
    for (int i = 1; i < ENTRY_TIMEOUT; i++)
      tbl.push_back(V(0, 0, 0, 0, 0, E(0, 0, 0, 2, 3, 1)));
    tbl.push_back(V(0, 0, 0, 0, 0, E(0, 0, 0, 0, 3, 0)));
    // Aborted reprogramming keeps old code; close beats enter
    add_code(1, 2, 3, 4, 3);
    tbl.push_back(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(1, 5, 0, 1, 0, E(1, 0, 0, 1, 3, 4)));
    tbl.push_back(V(1, 5, 0, 1, 0, E(1, 0, 0, 2, 3, 4)));
    tbl.push_back(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(1, 3, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(1, 1, 1, 0, 0, E(0, 0, 0, 0, 3, 0)));
    add_code(1, 2, 3, 4, 3);
    tbl.push_back(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    // Reprogram to 9876, old code rejected, new code accepted
    tbl.push_back(V(1, 9, 0, 1, 0, E(1, 0, 0, 1, 3, 4)));
    tbl.push_back(V(1, 8, 0, 1, 0, E(1, 0, 0, 2, 3, 4)));
    tbl.push_back(V(1, 7, 0, 1, 0, E(1, 0, 0, 3, 3, 4)));
    tbl.push_back(V(1, 6, 0, 1, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(0, 0, 1, 0, 0, E(0, 0, 0, 0, 3, 0)));
    add_code(1, 2, 3, 4, 3);
    tbl.push_back(V(0, 0, 0, 0, 0, E(0, 0, 1, 0, 2, 0)));
    add_code(9, 8, 7, 6, 2);
    tbl.push_back(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)));
    tbl.push_back(V(0, 0, 1, 0, 0, E(0, 0, 0, 0, 3, 0)));

    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

    // Asynchronous reset in the middle of reprogramming restores default code
    run_code(9, 8, 7, 6, 3, "new_code");
    step(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)), "new_open");
    step(V(1, 1, 0, 1, 0, E(1, 0, 0, 1, 3, 4)), "prog_part");
    step(V(1, 1, 0, 1, 0, E(1, 0, 0, 2, 3, 4)), "prog_part");
    drive_idle();
    #2 rst_n = 1'b0;
    #1;
    sb_q.push_back(E(0, 0, 0, 0, 3, 0));
    compare("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_code(1, 2, 3, 4, 3, "default_back");
    step(V(0, 0, 0, 0, 0, E(1, 0, 0, 0, 3, 3)), "default_open");
    step(V(0, 0, 1, 0, 0, E(0, 0, 0, 0, 3, 0)), "default_close");

    // Lockout: 20 cycles with enter ignored, then tries reload
    fail_three();
    for (int i = 1; i < LOCK_CYCLES; i++)
      step(V(1, 1, 0, 0, 0, E(0, 1, 0, 0, 0, 5)), "locked_hold");
    step(V(0, 0, 0, 0, 0, E(0, 0, 0, 0, 3, 0)), "lock_release");

`ifdef COFRE_EMERG_EN
    fail_three();
    step(V(0, 0, 0, 0, 0, E(0, 1, 0, 0, 0, 5)), "emerg_locked");
    step(V(0, 0, 0, 0, 1, E(1, 0, 0, 0, 3, 3)), "emerg_open");
    step(V(0, 0, 1, 0, 1, E(1, 0, 0, 0, 3, 3)), "emerg_close_ign");
    step(V(0, 0, 1, 0, 0, E(0, 0, 0, 0, 3, 0)), "emerg_close");
    step(V(1, 1, 0, 0, 0, E(0, 0, 0, 1, 3, 1)), "emerg_entry");
    step(V(0, 0, 0, 0, 1, E(1, 0, 0, 0, 3, 3)), "emerg_abort");
`else
    step(V(0, 0, 0, 0, 1, E(0, 0, 0, 0, 3, 0)), "h_ignored");
    step(V(1, 1, 0, 0, 1, E(0, 0, 0, 1, 3, 1)), "h_ignored_entry");
    step(V(0, 0, 0, 0, 1, E(0, 0, 0, 1, 3, 1)), "h_ignored_hold");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cofre_senha_seq.md
# cofre_senha_seq

Parametrised multi-digit code controller for the digital safe. It accepts a password as a sequence of DIGITS digit entries, compares the sequence against a stored code and opens the safe on a match. Repeated failures trigger a timed lockout, and the stored code can be reprogrammed while the safe is open. It replaces the single-entry state machine behind the board-level top: the top supplies clean one-cycle `enter`/`close` pulses and drives displays/LEDs from this block's outputs.

## Interface
- `DIGITS`, 4: number of digits per code (≥1)
- `DIGIT_W`, 4: bits per digit (one switch bank)
- `DEFAULT_PW`, 16'h1234: code loaded at reset, DIGITS*DIGIT_W bits; first-entered digit is the MS digit
- `MAX_TRIES`, 3: consecutive failures before lockout (≥1)
- `LOCK_CYCLES`, 20: lockout duration in clk cycles (≥1)
- `ENTRY_TIMEOUT`, 10: idle cycles allowed between digits during entry (≥1)

- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `enter`  in  1  one-cycle strobe; samples `digit`
- `digit`  in  DIGIT_W  digit value, valid when `enter`=1
- `close`  in  1  one-cycle strobe; relocks an open safe
- `prog`  in  1  level; with safe open, arms code reprogramming
- `H`  in  1  emergency key, level (see Configuration)
- `open`  out  1  safe unlocked
- `locked_out`  out  1  lockout active
- `err`  out  1  one-cycle pulse on wrong code
- `digits_in`  out  $clog2(DIGITS+1)  digits captured in current entry/prog sequence
- `tries_left`  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout
- `estado`  out  3  state code for debug LEDs

## Operation
- States / `estado`: IDLE=0, ENTRY=1, CHECK=2, OPEN=3, PROG=4, LOCKED=5.
- Reset values: state IDLE, stored code = DEFAULT_PW, `open`=0, `locked_out`=0, `err`=0, `digits_in`=0, `tries_left`=MAX_TRIES.
- Digit capture: shift register; each accepted `enter` shifts `digit` in at LS position; `digits_in` increments.
- IDLE: `enter` → capture digit, go ENTRY (or CHECK directly if DIGITS=1).
- ENTRY: `enter` captures next digit; on the DIGITS-th capture go CHECK. An idle counter is cleared on each `enter`; when ENTRY_TIMEOUT cycles pass without `enter` → IDLE, buffer and `digits_in` cleared, no failure counted.
- CHECK (exactly 1 cycle, `enter` ignored): match → OPEN, `tries_left`=MAX_TRIES. Mismatch → `err`=1 for that one cycle, `tries_left` decrements; if it reaches 0 → LOCKED, else → IDLE. `digits_in` is cleared on exit.
- OPEN: `open`=1. `close` → IDLE, with `close` taking priority over `enter` in the same cycle. `prog`=1 and `enter` → capture first digit, go PROG. Other `enter` is ignored.
- PROG: `open` stays 1. Each `enter` captures a digit. On the DIGITS-th capture the stored code is replaced at that edge; return to OPEN. If `prog` drops or `close` arrives before completion → abort, old code retained (`close` → IDLE, `prog` drop → OPEN). No timeout in PROG.
- LOCKED: `locked_out`=1 and `enter` ignored. The counter runs LOCK_CYCLES cycles, then → IDLE with `tries_left`=MAX_TRIES.
- `open` is high exactly in OPEN/PROG. `locked_out` is high exactly in LOCKED. All outputs are registered.

## Timing
- Last-digit `enter` at edge n → CHECK during cycle n+1 → `open` or `err` visible after edge n+1; latency 2 edges from last strobe to `open`.
- `close` at edge n → `open`=0 after edge n.
- Lockout: LOCKED entered at edge n → IDLE after edge n+LOCK_CYCLES.
- Timeout: last `enter` at edge n → IDLE after edge n+ENTRY_TIMEOUT.
- Reset mid-sequence: immediate asynchronous return to reset values; a PROG in progress is lost and the stored code reverts to DEFAULT_PW.

## Configuration
- `COFRE_EMERG_EN` defined: `H`=1 forces OPEN at the next edge from any state. This is the highest priority after reset: it aborts entry, PROG or LOCKED, and reloads `tries_left`=MAX_TRIES. While `H` stays 1 the block is held in OPEN and `close` is ignored.
- Not defined: `H` is ignored entirely; the port remains for pin compatibility.

## Test plan
- Defaults; enter 1,2,3,4 → `err` never pulses, `open`=1 two edges after the 4th strobe, `estado`=3; `close` → `open`=0, `estado`=0.
- Enter 1,2,3,5 three times → `err` pulses each time and `tries_left` steps 2,1,0; after the 3rd, `locked_out`=1 for exactly 20 cycles and enters are ignored; then `tries_left`=3.
- Enter 1,2 then wait 10 cycles → `estado`=0, `digits_in`=0, `tries_left` unchanged at 3.
- Open, hold `prog`=1, enter 9,8,7,6, `close`; enter 1,2,3,4 → `err`; enter 9,8,7,6 → `open`=1.
- Open, `prog`=1, enter 5,5, drop `prog` → `estado`=3; `close`; enter 1,2,3,4 → `open`=1 (old code kept).
- With `COFRE_EMERG_EN`: in LOCKED, raise `H` → `open`=1 next edge, `locked_out`=0, `tries_left`=3. Without the macro: `H`=1 has no effect.
